// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a req/ack handshake into a
// DEPTH-entry FIFO, and flushes and refetches from the target on a branch/jump redirect.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq,
    output logic                     valid,
    output logic [31:0]              instr,
    output logic [31:0]              pc_out,
    output logic [31:0]              pc_plus4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     fpc, fpc_nxt, tgt;
    logic [CW-1:0]   count_nxt;
    logic            push, pop;
    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];

    assign tgt       = redirect_pc & 32'hFFFF_FFFC;
    assign valid     = (count != '0);
    assign push      = (state == REQ) && mem_ack && !redirect;
    assign pop       = deq && valid && !redirect;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign fpc_nxt   = push ? fpc + 32'd4 : fpc;

    // While draining, fpc already holds the latched redirect target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (redirect || count < FULL) state_nxt = REQ;
            REQ: begin
                if (mem_ack) begin
                    state_nxt = (redirect || count_nxt < FULL) ? REQ : IDLE;
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   if (mem_ack) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state != IDLE);
    end

    // Control registers: occupancy, pointers, fetch pointer and the request address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fpc      <= RESET_PC;
            mem_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                fpc    <= tgt;
            end else begin
                count <= count_nxt;
                fpc   <= fpc_nxt;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            // The address only moves when no request is in flight or the current one completes.
            if (state == IDLE || mem_ack) begin
                mem_addr <= redirect ? tgt : fpc_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]    <= mem_addr;
        end
    end

    assign instr    = valid ? instr_mem[rd_ptr] : 32'h0;
    assign pc_out   = valid ? pc_mem[rd_ptr]    : 32'h0;
    assign pc_plus4 = pc_out + 32'd4;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed cycle table, reset/stream sequences, and a randomized
// run against a transaction-level queue model with a random-latency memory.
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, redirect, deq, mem_ack;
    logic [31:0] redirect_pc, mem_rdata;
    logic        valid, mem_req;
    logic [31:0] instr, pc_out, pc_plus4, mem_addr;
    logic [$clog2(DEPTH):0] count;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .valid(valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4), .count(count),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rd;
        logic [31:0] rpc;
        bit          dq;
        bit          ak;
        bit          ev;
        logic [31:0] ec;
        bit          er;
        logic [31:0] ea;
        logic [31:0] ep;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rd, input logic [31:0] rpc, input bit dq, input bit ak,
                       input bit ev, input logic [31:0] ec, input bit er,
                       input logic [31:0] ea, input logic [31:0] ep);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.dq = dq; v.ak = ak;
        v.ev = ev; v.ec = ec; v.er = er; v.ea = ea; v.ep = ep;
        tbl.push_back(v);
    endtask

    // Random-run model state
    logic [31:0] mq[$];
    logic [31:0] exp_fpc, prev_addr, exp_pc;
    bit          stale, in_flight, prev_pend, started;
    int          wait_left, got;

    initial begin
        // Inputs of a cycle | expected outputs sampled in that cycle before the edge
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b0, 32'd0, 1'b0, 32'h3000, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b0, 32'd0, 1'b1, 32'h3000, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b1,  1'b0, 32'd0, 1'b1, 32'h3000, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd1, 1'b1, 32'h3004, 32'h3000);
        add(1'b0, 32'h0,    1'b0, 1'b1,  1'b1, 32'd1, 1'b1, 32'h3004, 32'h3000);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd2, 1'b1, 32'h3008, 32'h3000);
        add(1'b0, 32'h0,    1'b0, 1'b1,  1'b1, 32'd2, 1'b1, 32'h3008, 32'h3000);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd3, 1'b1, 32'h300C, 32'h3000);
        add(1'b0, 32'h0,    1'b0, 1'b1,  1'b1, 32'd3, 1'b1, 32'h300C, 32'h3000);
        add(1'b0, 32'h0,    1'b1, 1'b0,  1'b1, 32'd4, 1'b0, 32'h3010, 32'h3000);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd3, 1'b0, 32'h3010, 32'h3004);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd3, 1'b1, 32'h3010, 32'h3004);
        add(1'b0, 32'h0,    1'b0, 1'b1,  1'b1, 32'd3, 1'b1, 32'h3010, 32'h3004);
        add(1'b0, 32'h0,    1'b1, 1'b0,  1'b1, 32'd4, 1'b0, 32'h3014, 32'h3004);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd3, 1'b0, 32'h3014, 32'h3008);
        add(1'b1, 32'h3201, 1'b0, 1'b1,  1'b1, 32'd3, 1'b1, 32'h3014, 32'h3008);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b0, 32'd0, 1'b1, 32'h3200, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b1,  1'b0, 32'd0, 1'b1, 32'h3200, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd1, 1'b1, 32'h3204, 32'h3200);
        add(1'b1, 32'h3180, 1'b0, 1'b0,  1'b1, 32'd1, 1'b1, 32'h3204, 32'h3200);
        add(1'b1, 32'h3100, 1'b0, 1'b0,  1'b0, 32'd0, 1'b1, 32'h3204, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b1,  1'b0, 32'd0, 1'b1, 32'h3204, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b0, 32'd0, 1'b1, 32'h3100, 32'h0);
        add(1'b0, 32'h0,    1'b1, 1'b1,  1'b0, 32'd0, 1'b1, 32'h3100, 32'h0);
        add(1'b0, 32'h0,    1'b0, 1'b0,  1'b1, 32'd1, 1'b1, 32'h3104, 32'h3100);

        rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; deq = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            chk($sformatf("tbl%0d_valid", i),   32'(valid),   32'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i),   32'(count),   tbl[i].ec);
            chk($sformatf("tbl%0d_req", i),     32'(mem_req), 32'(tbl[i].er));
            chk($sformatf("tbl%0d_addr", i),    mem_addr,     tbl[i].ea);
            chk($sformatf("tbl%0d_pc", i),      pc_out,       tbl[i].ep);
            chk($sformatf("tbl%0d_pc4", i),     pc_plus4,     tbl[i].ep + 32'd4);
            chk($sformatf("tbl%0d_instr", i),   instr,        tbl[i].ev ? ~tbl[i].ep : 32'h0);
            redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
            deq = tbl[i].dq; mem_ack = tbl[i].ak; mem_rdata = ~mem_addr;
            @(negedge clk);
        end

        // Reset asserted while a request is outstanding
        redirect = 1'b0; deq = 1'b0; mem_ack = 1'b0;
        chk("rst_mid_req_before", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h3000);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Streaming: ack every request, consume every cycle
        started = 1'b0; got = 0; exp_pc = 32'h3000;
        for (int c = 0; c < 30; c++) begin
            if (started) chk("stream_nogap", 32'(valid), 32'd1);
            if (valid) begin
                chk("stream_pc", pc_out, exp_pc);
                chk("stream_instr", instr, ~exp_pc);
                chk("stream_count", 32'(count), 32'd1);
                exp_pc += 32'd4;
                started = 1'b1;
                got++;
            end
            mem_ack = mem_req; mem_rdata = ~mem_addr; deq = 1'b1;
            @(negedge clk);
        end
        chk("stream_len", 32'(got), 32'd28);

        // Randomized run against the queue model
        mem_ack = 1'b0; deq = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mq.delete();
        exp_fpc = 32'h3000; stale = 1'b0; in_flight = 1'b0; prev_pend = 1'b0;
        prev_addr = 32'h0; wait_left = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rand_count", 32'(count), 32'(mq.size()));
            chk("rand_valid", 32'(valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rand_pc", pc_out, mq[0]);
                chk("rand_instr", instr, ~mq[0]);
            end else begin
                chk("rand_pc_empty", pc_out, 32'h0);
            end
            if (prev_pend) begin
                chk("rand_req_held", 32'(mem_req), 32'd1);
                chk("rand_addr_held", mem_addr, prev_addr);
            end

            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            deq = $urandom_range(0, 1) != 0;
            if (mem_req && !in_flight) begin
                in_flight = 1'b1;
                wait_left = $urandom_range(0, 3);
            end
            mem_ack = 1'b0;
            if (in_flight) begin
                if (wait_left == 0) mem_ack = 1'b1;
                else wait_left--;
            end
            mem_rdata = ~mem_addr;

            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (redirect) begin
                mq.delete();
                exp_fpc = redirect_pc & 32'hFFFF_FFFC;
            end else if (deq && mq.size() != 0) begin
                void'(mq.pop_front());
            end
            if (mem_ack) begin
                in_flight = 1'b0;
                if (!redirect && !stale) begin
                    chk("rand_fetch_addr", mem_addr, exp_fpc);
                    mq.push_back(exp_fpc);
                    exp_fpc += 32'd4;
                end
                stale = 1'b0;
            end else if (mem_req && redirect) begin
                stale = 1'b1;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
